// File: rtl/operand_stage_pkg.sv
// Shared definitions for the operand (issue) stage: widths, register-0 constant,
// forwarding-select encoding and the registered operand bundle.
package operand_stage_pkg;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 8;

    localparam logic [RA_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_WB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   op_b;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [RA_W-1:0]   rd;
        logic              rd_we;
        logic              is_load;
        logic [CTRL_W-1:0] ctrl;
    } op_bundle_t;

endpackage

// File: rtl/operand_stage_fwd_mux.sv
// Per-operand bypass mux: picks EX result, WB data or register-file data.
// x0 is never bypassed so it always reads as the register-file value.
module fwd_mux
    import operand_stage_pkg::*;
(
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_fwd_en,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] value
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (rs != ZERO_REG) begin
            // EX is younger than WB, so its value wins.
            if (ex_fwd_en && (ex_rd == rs))
                sel = FWD_EX;
            else if (wb_we && (wb_rd == rs))
                sel = FWD_WB;
        end
    end

    always_comb begin
        value = rf_data;
        case (sel)
            FWD_EX:  value = ex_result;
            FWD_WB:  value = wb_data;
            default: value = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_stage.sv
// Issue stage: register-file read, EX/WB bypass, load-use stall and the
// ID/EX pipeline register behind a valid/ready handshake.
module operand_stage
    import operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic              in_rd_we,
    input  logic              in_is_load,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [RA_W-1:0]   rf_rs1_addr,
    output logic [RA_W-1:0]   rf_rs2_addr,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,
    input  logic              ex_valid,
    input  logic              ex_rd_we,
    input  logic              ex_is_load,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              wb_we,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op_a,
    output logic [XLEN-1:0]   out_op_b,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_rd_we,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic       ex_fwd_en;
    logic       ex_load_wr;
    logic       hazard;
    logic       adv;
    op_bundle_t d;
    op_bundle_t q;

    assign rf_rs1_addr = in_rs1;
    assign rf_rs2_addr = in_rs2;

    // A load's data is not ready in EX, so it is never bypassed from there.
    assign ex_fwd_en  = ex_valid & ex_rd_we & ~ex_is_load;
    assign ex_load_wr = ex_valid & ex_is_load & ex_rd_we & (ex_rd != ZERO_REG);

    assign hazard = in_valid & ex_load_wr &
                    ((in_use_rs1 & (ex_rd == in_rs1)) | (in_use_rs2 & (ex_rd == in_rs2)));

    assign adv      = ~out_valid | out_ready;
    assign in_ready = flush | (adv & ~hazard);

    fwd_mux u_fwd_a (
        .rs        (in_rs1),
        .rf_data   (rf_rs1_data),
        .ex_fwd_en (ex_fwd_en),
        .ex_rd     (ex_rd),
        .ex_result (ex_result),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .value     (d.op_a)
    );

    fwd_mux u_fwd_b (
        .rs        (in_rs2),
        .rf_data   (rf_rs2_data),
        .ex_fwd_en (ex_fwd_en),
        .ex_rd     (ex_rd),
        .ex_result (ex_result),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .value     (d.op_b)
    );

    assign d.imm     = in_imm;
    assign d.pc      = in_pc;
    assign d.rd      = in_rd;
    assign d.rd_we   = in_rd_we;
    assign d.is_load = in_is_load;
    assign d.ctrl    = in_ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            // Hazard leaves a bubble; the instruction stays upstream for retry.
            if (hazard) begin
                out_valid <= 1'b0;
            end else if (in_valid) begin
                out_valid <= 1'b1;
                q         <= d;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_op_a    = q.op_a;
    assign out_op_b    = q.op_b;
    assign out_imm     = q.imm;
    assign out_pc      = q.pc;
    assign out_rd      = q.rd;
    assign out_rd_we   = q.rd_we;
    assign out_is_load = q.is_load;
    assign out_ctrl    = q.ctrl;

endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage: bypass priority, load-use
// bubble, x0 handling, back-pressure, flush and asynchronous reset.
module tb_operand_stage;
    import operand_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [RA_W-1:0]   in_rs1, in_rs2, in_rd;
    logic              in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
    logic [XLEN-1:0]   in_imm, in_pc;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RA_W-1:0]   rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data;
    logic              ex_valid, ex_rd_we, ex_is_load;
    logic [RA_W-1:0]   ex_rd;
    logic [XLEN-1:0]   ex_result;
    logic              wb_we;
    logic [RA_W-1:0]   wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              out_valid, out_ready;
    logic [XLEN-1:0]   out_op_a, out_op_b, out_imm, out_pc;
    logic [RA_W-1:0]   out_rd;
    logic              out_rd_we, out_is_load;
    logic [CTRL_W-1:0] out_ctrl;

    logic [XLEN-1:0] rf_mem [32];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rf_rs1_data = rf_mem[rf_rs1_addr];
    assign rf_rs2_data = rf_mem[rf_rs2_addr];

    operand_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_valid(ex_valid), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b),
        .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_is_load(out_is_load), .out_ctrl(out_ctrl)
    );

    task automatic quiet();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_rd_we = 0; in_is_load = 0;
        in_imm = 0; in_pc = 0; in_ctrl = 0;
        ex_valid = 0; ex_rd_we = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    task automatic issue(input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                         input logic [XLEN-1:0] pc);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_use_rs1 = 1; in_use_rs2 = 1;
        in_rd = 5'd9; in_rd_we = 1; in_is_load = 0;
        in_imm = pc + 32'h4; in_pc = pc; in_ctrl = pc[7:0] ^ 8'h5A;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        quiet();
        rst = 0;
        #12;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        tests++; if (out_op_a !== 32'h0 || out_pc !== 32'h0 || out_ctrl !== 8'h0) begin
            fails++; $display("FAIL reset_data op_a=%h pc=%h ctrl=%h want 0", out_op_a, out_pc, out_ctrl); end
        @(negedge clk); rst = 1;
        tick();
    endtask

    task automatic test_basic();
        quiet();
        issue(5'd3, 5'd4, 32'h100);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready got %0b want 1", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_op_a !== 32'h11 || out_op_b !== 32'h22) begin
            fails++; $display("FAIL basic_ops v=%0b a=%h b=%h want 1 11 22", out_valid, out_op_a, out_op_b); end
        tests++; if (out_pc !== 32'h100 || out_imm !== 32'h104 || out_rd !== 5'd9 || out_rd_we !== 1'b1 || out_ctrl !== 8'h5A) begin
            fails++; $display("FAIL basic_fields pc=%h imm=%h rd=%0d we=%0b ctrl=%h", out_pc, out_imm, out_rd, out_rd_we, out_ctrl); end
        issue(5'd5, 5'd7, 32'h104);
        tick();
        tests++; if (out_valid !== 1'b1 || out_op_a !== 32'h55 || out_op_b !== 32'h77 || out_pc !== 32'h104) begin
            fails++; $display("FAIL back_to_back v=%0b a=%h b=%h pc=%h want 1 55 77 104", out_valid, out_op_a, out_op_b, out_pc); end
        quiet();
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_forward();
        quiet();
        issue(5'd5, 5'd3, 32'h200);
        ex_valid = 1; ex_rd_we = 1; ex_rd = 5'd5; ex_result = 32'hAAAA;
        wb_we = 1; wb_rd = 5'd5; wb_data = 32'hBBBB;
        tick();
        tests++; if (out_op_a !== 32'hAAAA || out_op_b !== 32'h11) begin
            fails++; $display("FAIL fwd_ex a=%h b=%h want aaaa 11", out_op_a, out_op_b); end
        ex_rd_we = 0;
        tick();
        tests++; if (out_valid !== 1'b1 || out_op_a !== 32'hBBBB) begin
            fails++; $display("FAIL fwd_wb v=%0b a=%h want 1 bbbb", out_valid, out_op_a); end
    endtask

    task automatic test_load_use();
        quiet();
        issue(5'd3, 5'd7, 32'h300);
        ex_valid = 1; ex_rd_we = 1; ex_is_load = 1; ex_rd = 5'd7; ex_result = 32'hDEAD;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL lu_stall_ready got %0b want 0", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble got %0b want 0", out_valid); end
        ex_valid = 0; ex_is_load = 0; ex_rd_we = 0;
        wb_we = 1; wb_rd = 5'd7; wb_data = 32'h1234;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lu_retry_ready got %0b want 1", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_op_b !== 32'h1234 || out_op_a !== 32'h11) begin
            fails++; $display("FAIL lu_wb_fwd v=%0b a=%h b=%h want 1 11 1234", out_valid, out_op_a, out_op_b); end
        quiet();
        issue(5'd3, 5'd7, 32'h304);
        in_use_rs2 = 0;
        ex_valid = 1; ex_rd_we = 1; ex_is_load = 1; ex_rd = 5'd7; ex_result = 32'hDEAD;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lu_unused_ready got %0b want 1", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_op_b !== 32'h77 || out_pc !== 32'h304) begin
            fails++; $display("FAIL lu_unused_cap v=%0b b=%h pc=%h want 1 77 304", out_valid, out_op_b, out_pc); end
    endtask

    task automatic test_x0();
        quiet();
        issue(5'd0, 5'd0, 32'h400);
        ex_valid = 1; ex_rd_we = 1; ex_rd = 5'd0; ex_result = 32'hFFFF;
        wb_we = 1; wb_rd = 5'd0; wb_data = 32'hFFFF;
        tick();
        tests++; if (out_valid !== 1'b1 || out_op_a !== 32'h0 || out_op_b !== 32'h0) begin
            fails++; $display("FAIL x0_fwd v=%0b a=%h b=%h want 1 0 0", out_valid, out_op_a, out_op_b); end
        ex_is_load = 1; in_pc = 32'h404;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL x0_load_ready got %0b want 1", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_op_a !== 32'h0 || out_pc !== 32'h404) begin
            fails++; $display("FAIL x0_load_cap v=%0b a=%h pc=%h want 1 0 404", out_valid, out_op_a, out_pc); end
    endtask

    task automatic test_backpressure();
        quiet();
        issue(5'd3, 5'd4, 32'h500);
        tick();
        issue(5'd4, 5'd3, 32'h600);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d] got %0b want 0", i, in_ready); end
            tick();
            tests++; if (out_valid !== 1'b1 || out_op_a !== 32'h11 || out_op_b !== 32'h22 || out_pc !== 32'h500) begin
                fails++; $display("FAIL bp_hold[%0d] v=%0b a=%h b=%h pc=%h want 1 11 22 500", i, out_valid, out_op_a, out_op_b, out_pc); end
        end
        out_ready = 1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_op_a !== 32'h22 || out_op_b !== 32'h11 || out_pc !== 32'h600) begin
            fails++; $display("FAIL bp_release_cap v=%0b a=%h b=%h pc=%h want 1 22 11 600", out_valid, out_op_a, out_op_b, out_pc); end
    endtask

    task automatic test_flush();
        quiet();
        issue(5'd7, 5'd3, 32'h700);
        ex_valid = 1; ex_rd_we = 1; ex_is_load = 1; ex_rd = 5'd7;
        flush = 1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %0b want 1", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        quiet();
        issue(5'd3, 5'd4, 32'h800);
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid got %0b want 1", out_valid); end
        out_ready = 0;
        #2;
        rst = 0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_op_a !== 32'h0 || out_pc !== 32'h0) begin
            fails++; $display("FAIL ar_immediate v=%0b a=%h pc=%h want 0 0 0", out_valid, out_op_a, out_pc); end
        quiet();
        @(negedge clk); rst = 1;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_after got %0b want 0", out_valid); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 * i;
        rf_mem[0] = 32'h0;
        rf_mem[3] = 32'h11;
        rf_mem[4] = 32'h22;
        rf_mem[5] = 32'h55;
        rf_mem[7] = 32'h77;
        test_reset();
        test_basic();
        test_forward();
        test_load_use();
        test_x0();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Issue stage between decode and execute in the 32-bit RISC-V core.
- Drives the register-file read addresses and picks up the combinational read data.
- Resolves RAW hazards by forwarding from EX and WB; detects load-use hazards and inserts a one-cycle bubble.
- Registers the operand bundle into the ID/EX pipeline register using a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- CTRL_W, 8, opaque decoded-control bundle, passed through unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  decode holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs1, in_rs2, in_rd  in  RA_W each  source and destination register addresses.
- in_use_rs1, in_use_rs2  in  1 each  instruction actually reads rs1 / rs2.
- in_rd_we  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load.
- in_imm, in_pc  in  XLEN each  immediate and PC.
- in_ctrl  in  CTRL_W  control bundle.
- rf_rs1_addr, rf_rs2_addr  out  RA_W each  register-file read addresses; combinational copies of in_rs1 / in_rs2.
- rf_rs1_data, rf_rs2_data  in  XLEN each  combinational register-file read data.
- ex_valid, ex_rd_we, ex_is_load  in  1 each  state of the instruction currently in EX.
- ex_rd  in  RA_W  EX destination register.
- ex_result  in  XLEN  EX ALU result.
- wb_we  in  1  WB writes the register file this cycle.
- wb_rd  in  RA_W  WB destination register.
- wb_data  in  XLEN  WB data; this is the same write the register file commits at the next edge.
- flush  in  1  branch/jump redirect; kills this stage.
- out_valid  out  1  pipeline register holds a valid instruction.
- out_ready  in  1  EX accepts the instruction.
- out_op_a, out_op_b  out  XLEN each  resolved rs1 / rs2 values.
- out_imm, out_pc  out  XLEN each  registered immediate and PC.
- out_rd  out  RA_W  registered destination register.
- out_rd_we, out_is_load  out  1 each  registered flags.
- out_ctrl  out  CTRL_W  registered control bundle.

Behaviour:
- Reset (rst=0, asynchronous): all out_* registers cleared to 0, out_valid=0.
- Forwarding, per operand n in {1,2}:
  - Priority EX > WB > register file.
  - EX hit: ex_valid & ex_rd_we & !ex_is_load & ex_rd==in_rsn & ex_rd!=0.
  - WB hit: wb_we & wb_rd==in_rsn & wb_rd!=0.
  - Register 0 always resolves to the register-file value and is never forwarded.
- Hazard:
  - hazard = in_valid & ex_valid & ex_is_load & ex_rd_we & ex_rd!=0 & ((in_use_rs1 & ex_rd==in_rs1) | (in_use_rs2 & ex_rd==in_rs2)).
- Handshake:
  - adv = !out_valid | out_ready.
  - in_ready = flush | (adv & !hazard).
- Register update at each rising edge, highest priority first:
  1. flush=1: out_valid<=0; any input presented is dropped (in_ready=1 so decode drains).
  2. adv & hazard: out_valid<=0 (bubble); the input is held upstream and retried next cycle.
  3. adv & in_valid: capture the resolved operands and all pass-through fields; out_valid<=1.
  4. adv & !in_valid: out_valid<=0.
  5. !adv: hold every output register unchanged, including data.
- Latency: one cycle from acceptance to out_valid; load-use adds exactly one bubble cycle.
- Operands are sampled only in the capture cycle. Forward values present during stall cycles are irrelevant.
- out_* data fields may keep stale values while out_valid=0; the bench must not check them then.
- Simultaneous flush and hazard: flush wins, no stall.
- Reset asserted mid-stall: the stage returns to empty immediately.

Decomposition:
- Shared core package holds:
  - XLEN, RA_W, CTRL_W.
  - ZERO_REG = 0.
  - the forwarding-select encoding: FWD_RF=0, FWD_EX=1, FWD_WB=2.
- Sub-module fwd_mux (combinational, instantiated once per operand): inputs rs, rf_data and the EX/WB match terms; outputs the resolved value.
- Hazard detection, handshake and the pipeline register live in operand_stage.

Test Plan:
- No hazards, rs1=3 (rf=0x11), rs2=4 (rf=0x22), out_ready=1 -> next cycle out_valid=1, op_a=0x11, op_b=0x22; back-to-back issue at one instruction per cycle.
- EX writes x5=0xAAAA and WB writes x5=0xBBBB in the same cycle, rs1=5 -> op_a=0xAAAA; remove the EX match -> op_a=0xBBBB.
- EX load to x7, next instruction rs2=7 with in_use_rs2=1 -> in_ready=0 for 1 cycle and a bubble (out_valid=0); then, with WB forwarding 0x1234 -> op_b=0x1234. Same case with in_use_rs2=0 -> no stall.
- rs1=0 while EX and WB both write x0 with 0xFFFF -> op_a=0; no stall even if the EX instruction is a load.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> the next instruction is captured the following cycle.
- flush asserted together with in_valid and a hazard -> out_valid=0 next cycle, in_ready=1. Pulse rst=0 asynchronously mid-stream -> out_valid drops immediately.
